// File: rtl/seg_swap_sched.sv
// Display-assignment scheduler for the dual mod-6 counter seven-segment path.
// Optional build macro HOLD_BLINK_EN: blink the displays while in HOLD.
module seg_swap_sched #(
    parameter int PERIOD = 30,
    parameter int CW     = 5
) (
    input  logic          clk_slow,
    input  logic          rst,
    input  logic          en,
    input  logic          hold_req,
    input  logic          swap_req,
    output logic          sel,
    output logic          cnt_en,
    output logic          blank,
    output logic          swap_pulse,
    output logic [CW-1:0] tick_cnt,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_TICK = CW'(PERIOD - 1);
    localparam logic [CW-1:0] ONE_TICK  = CW'(1);

    state_t        state_r, state_s;
    logic          sel_r, sel_s;
    logic          cnt_en_r, cnt_en_s;
    logic          blank_r, blank_s;
    logic          pulse_r, pulse_s;
    logic [CW-1:0] tick_r, tick_s;
    // Set when HOLD was entered from SWAP: tick 0 has not yet been spent in RUN.
    logic          keep_r, keep_s;

    // Next-state selection following rst > en > hold_req > swap_req > expiry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_s = RUN;
                else    state_s = IDLE;
            end
            RUN: begin
                if (!en)                                   state_s = IDLE;
                else if (hold_req)                         state_s = HOLD;
                else if (swap_req || (tick_r == LAST_TICK)) state_s = SWAP;
                else                                       state_s = RUN;
            end
            SWAP: begin
                if (!en)           state_s = IDLE;
                else if (hold_req) state_s = HOLD;
                else               state_s = RUN;
            end
            HOLD: begin
                if (!en)           state_s = IDLE;
                else if (hold_req) state_s = HOLD;
                else               state_s = RUN;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output values to be registered alongside the state they belong to.
    always_comb begin
        sel_s    = sel_r;
        cnt_en_s = 1'b0;
        blank_s  = 1'b1;
        pulse_s  = 1'b0;
        tick_s   = tick_r;
        keep_s   = 1'b0;
        case (state_s)
            IDLE: begin
                tick_s = '0;
            end
            RUN: begin
                cnt_en_s = 1'b1;
                blank_s  = 1'b0;
                if ((state_r == IDLE) || (state_r == SWAP)) begin
                    tick_s = '0;
                end else if ((state_r == HOLD) && (keep_r || (tick_r == LAST_TICK))) begin
                    // Resuming at a tick value that was never spent in RUN, or at the
                    // last tick (which must not overflow into PERIOD).
                    tick_s = tick_r;
                end else begin
                    tick_s = tick_r + ONE_TICK;
                end
            end
            SWAP: begin
                sel_s    = ~sel_r;
                cnt_en_s = 1'b1;
                blank_s  = 1'b0;
                pulse_s  = 1'b1;
                tick_s   = '0;
            end
            HOLD: begin
                tick_s = tick_r;
                if (state_r == SWAP)      keep_s = 1'b1;
                else if (state_r == HOLD) keep_s = keep_r;
                else                      keep_s = 1'b0;
`ifdef HOLD_BLINK_EN
                if (state_r == HOLD) blank_s = ~blank_r;
                else                 blank_s = 1'b1;
`else
                blank_s = 1'b0;
`endif
            end
            default: begin
                tick_s = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            state_r  <= IDLE;
            sel_r    <= 1'b0;
            cnt_en_r <= 1'b0;
            blank_r  <= 1'b1;
            pulse_r  <= 1'b0;
            tick_r   <= '0;
            keep_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_s;
            cnt_en_r <= cnt_en_s;
            blank_r  <= blank_s;
            pulse_r  <= pulse_s;
            tick_r   <= tick_s;
            keep_r   <= keep_s;
        end
    end

    assign sel        = sel_r;
    assign cnt_en     = cnt_en_r;
    assign blank      = blank_r;
    assign swap_pulse = pulse_r;
    assign tick_cnt   = tick_r;
    assign state      = state_r;

endmodule

// File: tb/tb_seg_swap_sched.sv
// Scoreboard bench for seg_swap_sched: stimulus pushes the expected post-edge
// outputs, a monitor pops and compares one entry after every clk_slow edge.
module tb_seg_swap_sched;

    localparam int P  = 30;
    localparam int CW = 5;

    logic          clk_slow;
    logic          rst;
    logic          en;
    logic          hold_req;
    logic          swap_req;
    logic          sel;
    logic          cnt_en;
    logic          blank;
    logic          swap_pulse;
    logic [CW-1:0] tick_cnt;
    logic [1:0]    state;

    typedef struct {
        logic [1:0]    st;
        logic          sel;
        logic [CW-1:0] tick;
        logic          cen;
        logic          blank;
        logic          pulse;
        string         nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    seg_swap_sched #(.PERIOD(P), .CW(CW)) dut (
        .clk_slow   (clk_slow),
        .rst        (rst),
        .en         (en),
        .hold_req   (hold_req),
        .swap_req   (swap_req),
        .sel        (sel),
        .cnt_en     (cnt_en),
        .blank      (blank),
        .swap_pulse (swap_pulse),
        .tick_cnt   (tick_cnt),
        .state      (state)
    );

    initial begin
        clk_slow = 1'b0;
        forever #5 clk_slow = ~clk_slow;
    end

    // Expected blank during the i-th HOLD cycle (0-based).
    function automatic logic hb(input int i);
`ifdef HOLD_BLINK_EN
        return (i % 2 == 0) ? 1'b1 : 1'b0;
`else
        return (i < 0) ? 1'b1 : 1'b0;
`endif
    endfunction

    task automatic step(input logic r, input logic e, input logic h, input logic s,
                        input logic [1:0] xs, input logic xsel, input int xt,
                        input logic xc, input logic xb, input logic xp, input string nm);
        exp_t x;
        @(negedge clk_slow);
        rst      = r;
        en       = e;
        hold_req = h;
        swap_req = s;
        x.st    = xs;
        x.sel   = xsel;
        x.tick  = CW'(xt);
        x.cen   = xc;
        x.blank = xb;
        x.pulse = xp;
        x.nm    = nm;
        q.push_back(x);
    endtask

    task automatic run_ticks(input logic xsel, input int from, input int to, input string nm);
        for (int k = from; k <= to; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, xsel, k, 1'b1, 1'b0, 1'b0, nm);
        end
    endtask

    // Monitor: compare the outputs presented after each edge against the queue head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_slow);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if ({state, sel, tick_cnt, cnt_en, blank, swap_pulse} !==
                    {x.st, x.sel, x.tick, x.cen, x.blank, x.pulse}) begin
                    failures++;
                    $display("FAIL %s: got state=%0d sel=%0b tick=%0d cnt_en=%0b blank=%0b pulse=%0b, want state=%0d sel=%0b tick=%0d cnt_en=%0b blank=%0b pulse=%0b",
                             x.nm, state, sel, tick_cnt, cnt_en, blank, swap_pulse,
                             x.st, x.sel, x.tick, x.cen, x.blank, x.pulse);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; hold_req = 1'b0; swap_req = 1'b0;
        // Reset, then free run with two automatic swaps
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "reset1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "run_entry");
        run_ticks(1'b0, 1, P - 1, "free_run_a");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 0, 1'b1, 1'b0, 1'b1, "expiry_swap_a");
        run_ticks(1'b1, 0, P - 1, "free_run_b");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 1'b1, 1'b0, 1'b1, "expiry_swap_b");
        // Manual swap, ignored request during SWAP, coincident request+expiry
        run_ticks(1'b0, 0, 7, "pre_manual");
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 0, 1'b1, 1'b0, 1'b1, "manual_swap");
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 0, 1'b1, 1'b0, 1'b0, "swap_req_in_swap");
        run_ticks(1'b1, 1, P - 1, "to_coincident");
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 0, 1'b1, 1'b0, 1'b1, "coincident_swap");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "after_coincident");
        // Hold at tick 12 for 5 cycles with swap requests ignored
        run_ticks(1'b0, 1, 12, "pre_hold");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, (i == 1 || i == 3) ? 1'b1 : 1'b0,
                 2'd3, 1'b0, 12, 1'b0, hb(i), 1'b0, "hold");
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 13, 1'b1, 1'b0, 1'b0, "hold_release");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 14, 1'b1, 1'b0, 1'b0, "hold_resume");
        run_ticks(1'b0, 15, P - 1, "to_swap_c");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 0, 1'b1, 1'b0, 1'b1, "expiry_swap_c");
        // en dropped in HOLD keeps sel; reset during SWAP clears sel
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 0, 1'b0, hb(0), 1'b0, "swap_to_hold");
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b1, 1'b0, "en_drop_in_hold");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 0, 1'b1, 1'b0, 1'b0, "rerun_sel_kept");
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 0, 1'b1, 1'b0, 1'b1, "manual_swap_b");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "after_swap_b");
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 0, 1'b1, 1'b0, 1'b1, "manual_swap_c");
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "reset_in_swap");
        // en rising with hold high: IDLE -> RUN -> HOLD
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0, "en_rise_hold");
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 0, 1'b0, hb(0), 1'b0, "hold_after_rise");
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1, 1'b1, 1'b0, 1'b0, "release_after_rise");
        // 4-cycle hold blank pattern
        run_ticks(1'b0, 2, 3, "pre_blink");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 3, 1'b0, hb(i), 1'b0, "blink_hold");
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4, 1'b1, 1'b0, 1'b0, "blink_release");
        // en low from RUN, then hold_req in IDLE has no effect
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "en_drop_run");
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "idle_hold_ignored");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk_slow);
        #2;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
